// File: rtl/std_fp_mult_arb_if.sv
// rtl/std_fp_mult_arb_if.sv - requester-side bundle for the shared fixed-point multiplier
interface std_fp_mult_arb_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       go;
    logic [NUM_REQ*WIDTH-1:0] left;
    logic [NUM_REQ*WIDTH-1:0] right;
    logic [NUM_REQ*WIDTH-1:0] out;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;

    modport master (
        output go,
        output left,
        output right,
        input  out,
        input  done,
        input  busy
    );

    modport slave (
        input  go,
        input  left,
        input  right,
        output out,
        output done,
        output busy
    );
endinterface

// File: rtl/std_fp_mult_arb.sv
// rtl/std_fp_mult_arb.sv - round-robin arbitrated unsigned fixed-point multiplier, 3-stage pipeline
module std_fp_mult_arb #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic              clk,
    input  logic              reset,
    std_fp_mult_arb_if.slave  bus
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time parameter sanity
    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_width
        $error("WIDTH must equal INT_WIDTH + FRAC_WIDTH");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end

    logic [TAG_W-1:0]         ptr;
    logic [TAG_W-1:0]         grant_idx;
    logic                     grant_valid;
    logic [NUM_REQ-1:0]       pend;
    logic [NUM_REQ-1:0]       done_q;
    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       set_mask;
    logic [NUM_REQ-1:0]       fin_mask;

    logic                     s1_valid;
    logic [TAG_W-1:0]         s1_tag;
    logic [WIDTH-1:0]         s1_a;
    logic [WIDTH-1:0]         s1_b;

    logic                     s2_valid;
    logic [TAG_W-1:0]         s2_tag;
    logic [2*WIDTH-1:0]       s2_prod;

    logic [NUM_REQ*WIDTH-1:0] out_q;

    // A requester is skipped while its op is in flight and during its done cycle
    assign eligible = bus.go & ~pend & ~done_q;

    // Round-robin scan starting at ptr; no grant while reset is asserted
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'(idx);
            end
        end
        if (reset) begin
            grant_valid = 1'b0;
        end
    end

    // One-hot masks for the requester being granted and the one completing
    always_comb begin
        set_mask = '0;
        fin_mask = '0;
        if (grant_valid) begin
            set_mask = NUM_REQ'(1) << grant_idx;
        end
        if (s2_valid) begin
            fin_mask = NUM_REQ'(1) << s2_tag;
        end
    end

    // Pointer moves just past the winner; holds when nobody is granted
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_valid) begin
            if (grant_idx == TAG_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + TAG_W'(1);
            end
        end
    end

    // Pending flags: set on grant, dropped at the edge that raises done
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~fin_mask) | set_mask;
        end
    end

    // Stage 1: capture the winner's operands with its tag
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= grant_valid;
            if (grant_valid) begin
                s1_tag <= grant_idx;
                s1_a   <= bus.left[grant_idx*WIDTH +: WIDTH];
                s1_b   <= bus.right[grant_idx*WIDTH +: WIDTH];
            end
        end
    end

    // Stage 2: full-width unsigned product
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            s2_prod  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag  <= s1_tag;
                s2_prod <= (2*WIDTH)'(s1_a) * (2*WIDTH)'(s1_b);
            end
        end
    end

    // Stage 3: write the truncated result into the owner's slice and pulse its done
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            done_q <= '0;
        end else begin
            done_q <= fin_mask;
            if (s2_valid) begin
                out_q[s2_tag*WIDTH +: WIDTH] <= WIDTH'(s2_prod >> FRAC_WIDTH);
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.busy = |pend;

endmodule

// File: tb/tb_std_fp_mult_arb.sv
// tb/tb_std_fp_mult_arb.sv - self-checking bench for std_fp_mult_arb
module tb_std_fp_mult_arb;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    std_fp_mult_arb_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    std_fp_mult_arb #(
        .WIDTH(W), .INT_WIDTH(16), .FRAC_WIDTH(16), .NUM_REQ(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int         tag;
        logic [W-1:0] res;
        int         g;
    } op_t;

    typedef struct {
        int           req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    op_t          q[$];
    logic [W-1:0] m_out[N];
    int           m_ptr;
    int           cyc;
    bit           known;
    int           n_checks;
    int           n_errors;
    logic [N-1:0] last_done;
    vec_t         vt[8];

    function automatic logic [W-1:0] fx_mul(logic [W-1:0] a, logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = 64'(a) * 64'(b);
        return W'(p / 64'd65536);
    endfunction

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic set_op(int r, logic [W-1:0] a, logic [W-1:0] b);
        bus.left[r*W +: W]  = a;
        bus.right[r*W +: W] = b;
    endtask

    // One clock cycle: reference model predicts this cycle's outputs, compares, then decides the grant
    task automatic run_cycle();
        logic [N-1:0]   edone;
        logic [N-1:0]   epend;
        logic [N-1:0]   elig;
        logic [N*W-1:0] eout;
        int             gi;
        int             j;
        edone = '0;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].g + 3 == cyc) begin
                m_out[q[k].tag] = q[k].res;
                edone[q[k].tag] = 1'b1;
                q.delete(k);
            end
        end
        epend = '0;
        foreach (q[k]) epend[q[k].tag] = 1'b1;
        for (int i = 0; i < N; i++) eout[i*W +: W] = m_out[i];
        last_done = bus.done;
        if (known) begin
            check("model_done", bus.done, edone);
            check("model_busy", bus.busy, |epend);
            check("model_out", bus.out, eout);
        end
        if (reset) begin
            q.delete();
            for (int i = 0; i < N; i++) m_out[i] = '0;
            m_ptr = 0;
            known = 1'b1;
        end else begin
            elig = bus.go & ~epend & ~edone;
            gi = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (gi < 0 && elig[j]) gi = j;
            end
            if (gi >= 0) begin
                q.push_back('{tag: gi, res: fx_mul(bus.left[gi*W +: W], bus.right[gi*W +: W]), g: cyc});
                m_ptr = (gi + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        bus.go = '0;
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] exp_d[10];
        bus.go = '0;
        bus.left = '0;
        bus.right = '0;
        known = 1'b0;
        cyc = 0;
        m_ptr = 0;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < N; i++) m_out[i] = '0;

        vt[0] = '{req: 0, a: 32'h0001_8000, b: 32'h0002_0000, exp: 32'h0003_0000};
        vt[1] = '{req: 0, a: 32'h0100_0000, b: 32'h0100_0000, exp: 32'h0000_0000};
        vt[2] = '{req: 0, a: 32'h0000_0001, b: 32'h0000_8000, exp: 32'h0000_0000};
        vt[3] = '{req: 1, a: 32'h0001_0000, b: 32'h0001_0000, exp: 32'h0001_0000};
        vt[4] = '{req: 2, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFE_0000};
        vt[5] = '{req: 3, a: 32'h0002_8000, b: 32'h0000_4000, exp: 32'h0000_A000};
        vt[6] = '{req: 1, a: 32'h1234_5678, b: 32'h0001_0000, exp: 32'h1234_5678};
        vt[7] = '{req: 3, a: 32'h0000_0003, b: 32'h0000_0002, exp: 32'h0000_0000};

        @(negedge clk);
        reset = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        check("rst_out", bus.out, '0);
        check("rst_done", bus.done, '0);
        check("rst_busy", bus.busy, 1'b0);

        // Table-driven single requests: done exactly in cycle 3, result in the owner's slice
        foreach (vt[v]) begin
            set_op(vt[v].req, vt[v].a, vt[v].b);
            bus.go = N'(1) << vt[v].req;
            run_cycle();
            bus.go = '0;
            run_cycle();
            run_cycle();
            check("vec_done_early", last_done, '0);
            run_cycle();
            check("vec_done", last_done, N'(1) << vt[v].req);
            check("vec_out", bus.out[vt[v].req*W +: W], vt[v].exp);
            run_cycle();
            check("vec_done_drop", last_done, '0);
        end

        // All four requesting together: grants 0..3, dones one-hot in order
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'h0001_0000 * (i + 2), 32'h0000_C000 + 32'(i));
        exp_d = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        for (int c = 0; c < 8; c++) begin
            bus.go = (c < 4) ? 4'b1111 : 4'b0000;
            run_cycle();
            check("all_req_done", last_done, exp_d[c]);
        end

        // Round robin: grant to 2 leaves ptr at 3, so 3 beats 1
        do_reset();
        exp_d = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int c = 0; c < 7; c++) begin
            bus.go = (c == 0) ? 4'b0100 : (c < 3) ? 4'b1010 : 4'b0000;
            run_cycle();
            check("rr_done", last_done, exp_d[c]);
        end

        // Held request: re-granted the cycle after its done
        do_reset();
        set_op(0, 32'h0003_0000, 32'h0000_4000);
        for (int c = 0; c < 10; c++) begin
            bus.go = (c < 8) ? 4'b0001 : 4'b0000;
            run_cycle();
            check("hold_done", last_done, (c == 3 || c == 7) ? 4'b0001 : 4'b0000);
        end

        // Reset mid-operation: nothing completes, and the pointer is back at 0
        do_reset();
        set_op(0, 32'h0005_0000, 32'h0002_0000);
        set_op(1, 32'h0007_0000, 32'h0001_0000);
        bus.go = 4'b0001;
        run_cycle();
        bus.go = '0;
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        for (int c = 2; c < 7; c++) begin
            run_cycle();
            check("rst_mid_done", last_done, '0);
            check("rst_mid_busy", bus.busy, 1'b0);
        end
        check("rst_mid_out", bus.out, '0);
        exp_d = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int c = 0; c < 6; c++) begin
            bus.go = (c < 2) ? 4'b0011 : 4'b0000;
            run_cycle();
            check("rst_ptr_done", last_done, exp_d[c]);
        end

        // Randomised traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            bus.go = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)
                    set_op(i, 32'($urandom_range(0, 32'h0004_0000)), 32'($urandom_range(0, 32'h0004_0000)));
                else
                    set_op(i, $urandom, $urandom);
            end
            reset = ($urandom_range(0, 49) == 0);
            run_cycle();
        end
        reset = 1'b0;
        bus.go = '0;
        for (int c = 0; c < 8; c++) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
